// File: rtl/cpu_phase_scheduler_if.sv
// Control and strobe bundle between the core's sequencer and the phase scheduler.
// The master side drives run/step/halt/mem_wait and the slave side returns the phase strobes and status.
interface cpu_phase_scheduler_if #(
  parameter int CNT_W = 32
);

  logic             run;
  logic             step;
  logic             halt_req;
  logic             mem_wait;

  logic             en_fetch;
  logic             en_alu;
  logic             en_mem;
  logic             en_wb;
  logic             busy;
  logic [1:0]       phase;
  logic [7:0]       slot_cnt;
  logic [CNT_W-1:0] retired;

  modport master (
    output run,
    output step,
    output halt_req,
    output mem_wait,
    input  en_fetch,
    input  en_alu,
    input  en_mem,
    input  en_wb,
    input  busy,
    input  phase,
    input  slot_cnt,
    input  retired
  );

  modport slave (
    input  run,
    input  step,
    input  halt_req,
    input  mem_wait,
    output en_fetch,
    output en_alu,
    output en_mem,
    output en_wb,
    output busy,
    output phase,
    output slot_cnt,
    output retired
  );

endinterface

// File: rtl/cpu_phase_scheduler.sv
// Instruction-slot scheduler: one-cycle fetch/ALU/mem/writeback enables on clk_100M,
// with run/step/halt control, memory wait-state stretching and a retired-slot counter.
module cpu_phase_scheduler #(
  parameter int PERIOD   = 100,
  parameter int PH_FETCH = 5,
  parameter int PH_ALU   = 50,
  parameter int PH_MEM   = 80,
  parameter int PH_WB    = 90,
  parameter int CNT_W    = 32
) (
  input  logic                  clk_100M,
  input  logic                  rst_n,
  cpu_phase_scheduler_if.slave  bus
);

  localparam logic [7:0] SLOT_LAST   = 8'(PERIOD - 1);
  localparam logic [7:0] SLOT_FETCH  = 8'(PH_FETCH);
  localparam logic [7:0] SLOT_ALU    = 8'(PH_ALU);
  localparam logic [7:0] SLOT_MEM    = 8'(PH_MEM);
  localparam logic [7:0] SLOT_WB     = 8'(PH_WB);
  localparam logic [7:0] SLOT_RESUME = 8'(PH_MEM + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             mode_run;
  logic             mode_run_next;
  logic [7:0]       slot;
  logic [7:0]       slot_next;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] retired_next;
  logic             halt_latch;
  logic             halt_latch_next;
  logic             active;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_run   <= 1'b0;
      slot       <= 8'd0;
      retired    <= '0;
      halt_latch <= 1'b0;
    end else begin
      state      <= state_next;
      mode_run   <= mode_run_next;
      slot       <= slot_next;
      retired    <= retired_next;
      halt_latch <= halt_latch_next;
    end
  end

  // Halt is sticky until run is seen low while idle, so a held run cannot restart on its own.
  always_comb begin
    state_next      = state;
    mode_run_next   = mode_run;
    slot_next       = slot;
    retired_next    = retired;
    halt_latch_next = halt_latch;

    if (state != IDLE && bus.halt_req) begin
      halt_latch_next = 1'b1;
    end else if (state == IDLE && !bus.run) begin
      halt_latch_next = 1'b0;
    end

    case (state)
      IDLE: begin
        slot_next = 8'd0;
        if (bus.run && !halt_latch) begin
          state_next    = RUN;
          mode_run_next = 1'b1;
        end else if (bus.step) begin
          state_next    = STEP;
          mode_run_next = 1'b0;
        end
      end

      RUN, STEP: begin
        if (slot == SLOT_MEM && bus.mem_wait) begin
          state_next = MEMWAIT;
        end else if (slot == SLOT_LAST) begin
          retired_next = retired + CNT_W'(1);
          slot_next    = 8'd0;
          if (state == STEP || !bus.run || halt_latch) begin
            state_next = IDLE;
          end
        end else begin
          slot_next = slot + 8'd1;
        end
      end

      MEMWAIT: begin
        if (!bus.mem_wait) begin
          slot_next  = SLOT_RESUME;
          state_next = mode_run ? RUN : STEP;
        end
      end

      default: begin
        state_next = IDLE;
        slot_next  = 8'd0;
      end
    endcase
  end

  // Everything visible is decoded from registers only; MEMWAIT suppresses the strobes.
  always_comb begin
    active       = (state == RUN) || (state == STEP);
    bus.en_fetch = active && (slot == SLOT_FETCH);
    bus.en_alu   = active && (slot == SLOT_ALU);
    bus.en_mem   = active && (slot == SLOT_MEM);
    bus.en_wb    = active && (slot == SLOT_WB);
    bus.busy     = (state != IDLE);
    bus.slot_cnt = slot;
    bus.retired  = retired;

    if (state == IDLE) begin
      bus.phase = 2'd0;
    end else if (state == MEMWAIT) begin
      bus.phase = 2'd2;
    end else if (slot < SLOT_ALU) begin
      bus.phase = 2'd0;
    end else if (slot < SLOT_MEM) begin
      bus.phase = 2'd1;
    end else if (slot < SLOT_WB) begin
      bus.phase = 2'd2;
    end else begin
      bus.phase = 2'd3;
    end
  end

endmodule

// File: tb/tb_cpu_phase_scheduler.sv
// Scoreboard bench for cpu_phase_scheduler: expected strobes are queued as stimulus is
// applied and matched against the DUT strobes as they appear.
module tb_cpu_phase_scheduler;

  localparam int PERIOD   = 100;
  localparam int PH_FETCH = 5;
  localparam int PH_ALU   = 50;
  localparam int PH_MEM   = 80;
  localparam int PH_WB    = 90;

  typedef struct {
    int kind;
    int cyc;
    int slot;
  } sb_entry_t;

  logic clk_100M;
  logic rst_n;
  logic rst4_n;

  int checks;
  int failures;
  int cyc;
  int busy_cycles;

  sb_entry_t sb[$];

  cpu_phase_scheduler_if #(.CNT_W(32)) bus ();
  cpu_phase_scheduler_if #(.CNT_W(4))  bus4 ();

  cpu_phase_scheduler #(
    .PERIOD(PERIOD), .PH_FETCH(PH_FETCH), .PH_ALU(PH_ALU),
    .PH_MEM(PH_MEM), .PH_WB(PH_WB), .CNT_W(32)
  ) dut (
    .clk_100M(clk_100M),
    .rst_n(rst_n),
    .bus(bus)
  );

  cpu_phase_scheduler #(
    .PERIOD(PERIOD), .PH_FETCH(PH_FETCH), .PH_ALU(PH_ALU),
    .PH_MEM(PH_MEM), .PH_WB(PH_WB), .CNT_W(4)
  ) dut4 (
    .clk_100M(clk_100M),
    .rst_n(rst4_n),
    .bus(bus4)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  initial cyc = 0;
  always @(posedge clk_100M) cyc++;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic h, input logic m);
    bus.run      = r;
    bus.step     = s;
    bus.halt_req = h;
    bus.mem_wait = m;
  endtask

  task automatic push_slot(input int s, input int extra, input int n_ph);
    int ph[4];
    sb_entry_t e;
    ph = '{PH_FETCH, PH_ALU, PH_MEM, PH_WB};
    for (int i = 0; i < n_ph; i++) begin
      e.kind = i;
      e.slot = ph[i];
      e.cyc  = s + ph[i] + ((i == 3) ? extra : 0);
      sb.push_back(e);
    end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) @(negedge clk_100M);
  endtask

  task automatic check_all_zero(input string pfx);
    check_output({pfx, "_busy"}, 64'(bus.busy), 64'd0);
    check_output({pfx, "_slot"}, 64'(bus.slot_cnt), 64'd0);
    check_output({pfx, "_phase"}, 64'(bus.phase), 64'd0);
    check_output({pfx, "_retired"}, 64'(bus.retired), 64'd0);
    check_output({pfx, "_strobes"},
                 64'({bus.en_wb, bus.en_mem, bus.en_alu, bus.en_fetch}), 64'd0);
  endtask

  // Strobe monitor: samples just after the falling edge so stimulus reads see the previous count.
  initial busy_cycles = 0;
  always begin
    logic [3:0] ens;
    sb_entry_t  e;
    @(negedge clk_100M);
    #1;
    ens = {bus.en_wb, bus.en_mem, bus.en_alu, bus.en_fetch};
    if (ens != 4'd0) begin
      if (sb.size() == 0) begin
        check_output("unexpected_strobe", 64'(ens), 64'd0);
      end else begin
        e = sb.pop_front();
        check_output("strobe_kind", 64'(ens), 64'(4'd1 << e.kind));
        check_output("strobe_cycle", 64'(cyc), 64'(e.cyc));
        check_output("strobe_slot", 64'(bus.slot_cnt), 64'(e.slot));
        check_output("strobe_phase", 64'(bus.phase), 64'(e.kind));
      end
    end
    if (bus.busy) busy_cycles++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int s2;
    int b0;
    int b1;
    int bad;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rst4_n   = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    bus4.run      = 1'b0;
    bus4.step     = 1'b0;
    bus4.halt_req = 1'b0;
    bus4.mem_wait = 1'b0;

    repeat (3) @(negedge clk_100M);
    check_all_zero("reset");
    check_output("reset4_retired", 64'(bus4.retired), 64'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk_100M);
    check_output("idle_busy", 64'(bus.busy), 64'd0);

    // Free run for three slots
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 0, 4);
    push_slot(s + PERIOD, 0, 4);
    push_slot(s + 2 * PERIOD, 0, 4);
    go_to(s);
    b0 = busy_cycles;
    check_output("t1_start_slot", 64'(bus.slot_cnt), 64'd0);
    go_to(s + 250);
    check_output("t1_slot_mid", 64'(bus.slot_cnt), 64'd50);
    check_output("t1_phase_mid", 64'(bus.phase), 64'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(s + 300);
    check_output("t1_busy_cycles", 64'(busy_cycles - b0), 64'd300);
    check_output("t1_busy_end", 64'(bus.busy), 64'd0);
    check_output("t1_retired", 64'(bus.retired), 64'd3);
    check_output("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Single step; a second step mid-slot is ignored
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 0, 4);
    go_to(s);
    b0 = busy_cycles;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(s + 40);
    check_output("t2_slot40", 64'(bus.slot_cnt), 64'd40);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    go_to(s + 41);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    go_to(s + 100);
    check_output("t2_busy_cycles", 64'(busy_cycles - b0), 64'd100);
    check_output("t2_busy_end", 64'(bus.busy), 64'd0);
    check_output("t2_retired", 64'(bus.retired), 64'd4);
    b1 = busy_cycles;
    go_to(s + 250);
    check_output("t2_idle_after", 64'(busy_cycles - b1), 64'd0);
    check_output("t2_retired_hold", 64'(bus.retired), 64'd4);
    check_output("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Memory wait of ten cycles at the mem phase
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 10, 4);
    go_to(s);
    b0 = busy_cycles;
    go_to(s + 60);
    bus.mem_wait = 1'b1;
    go_to(s + 61);
    bus.mem_wait = 1'b0;
    check_output("t3_wait_ignored", 64'(bus.slot_cnt), 64'd61);
    go_to(s + 80);
    bus.mem_wait = 1'b1;
    bad = 0;
    for (int k = 81; k <= 90; k++) begin
      go_to(s + k);
      if (bus.slot_cnt != 8'(PH_MEM) || bus.phase != 2'd2) bad++;
    end
    bus.mem_wait = 1'b0;
    check_output("t3_wait_hold", 64'(bad), 64'd0);
    go_to(s + 91);
    check_output("t3_resume_slot", 64'(bus.slot_cnt), 64'd81);
    go_to(s + 95);
    bus.run = 1'b0;
    go_to(s + 110);
    check_output("t3_slot_len", 64'(busy_cycles - b0), 64'd110);
    check_output("t3_busy_end", 64'(bus.busy), 64'd0);
    check_output("t3_retired", 64'(bus.retired), 64'd5);
    check_output("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Halt mid-slot with run held, then restart via run low/high
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 0, 4);
    go_to(s);
    b0 = busy_cycles;
    go_to(s + 30);
    bus.halt_req = 1'b1;
    go_to(s + 31);
    bus.halt_req = 1'b0;
    go_to(s + 100);
    check_output("t4_busy_cycles", 64'(busy_cycles - b0), 64'd100);
    check_output("t4_busy_end", 64'(bus.busy), 64'd0);
    check_output("t4_retired", 64'(bus.retired), 64'd6);
    b1 = busy_cycles;
    go_to(s + 150);
    check_output("t4_halted_hold", 64'(busy_cycles - b1), 64'd0);
    bus.run = 1'b0;
    go_to(s + 152);
    bus.run = 1'b1;
    s2 = cyc + 1;
    push_slot(s2, 0, 4);
    go_to(s2);
    check_output("t4_restart_slot", 64'(bus.slot_cnt), 64'd0);
    check_output("t4_restart_busy", 64'(bus.busy), 64'd1);
    go_to(s2 + 50);
    bus.run = 1'b0;
    go_to(s2 + 100);
    check_output("t4_busy_end2", 64'(bus.busy), 64'd0);
    check_output("t4_retired2", 64'(bus.retired), 64'd7);

    // run and step together: run wins; dropping run mid-slot finishes the slot
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 0, 4);
    push_slot(s + PERIOD, 0, 4);
    go_to(s);
    bus.step = 1'b0;
    b0 = busy_cycles;
    go_to(s + 160);
    bus.run = 1'b0;
    go_to(s + 200);
    check_output("t5_busy_cycles", 64'(busy_cycles - b0), 64'd200);
    check_output("t5_busy_end", 64'(bus.busy), 64'd0);
    check_output("t5_retired", 64'(bus.retired), 64'd9);
    check_output("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset while stalled in MEMWAIT
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    s = cyc + 1;
    push_slot(s, 0, 3);
    go_to(s + 80);
    bus.mem_wait = 1'b1;
    go_to(s + 85);
    check_output("t6_memwait_slot", 64'(bus.slot_cnt), 64'd80);
    check_output("t6_memwait_phase", 64'(bus.phase), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    bus.mem_wait = 1'b0;
    go_to(s + 86);
    check_output("t6_held_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    s2 = cyc + 1;
    push_slot(s2, 0, 4);
    go_to(s2);
    check_output("t6_restart_slot", 64'(bus.slot_cnt), 64'd0);
    check_output("t6_restart_busy", 64'(bus.busy), 64'd1);
    check_output("t6_restart_retired", 64'(bus.retired), 64'd0);
    go_to(s2 + 50);
    bus.run = 1'b0;
    go_to(s2 + 100);
    check_output("t6_busy_end", 64'(bus.busy), 64'd0);
    check_output("t6_retired", 64'(bus.retired), 64'd1);
    check_output("t6_sb_empty", 64'(sb.size()), 64'd0);

    // Narrow retired counter wraps after sixteen slots
    bus4.run = 1'b1;
    s = cyc + 1;
    go_to(s + 1550);
    check_output("t6w_retired15", 64'(bus4.retired), 64'd15);
    check_output("t6w_slot", 64'(bus4.slot_cnt), 64'd50);
    go_to(s + 1650);
    check_output("t6w_retired_wrap", 64'(bus4.retired), 64'd0);
    check_output("t6w_busy", 64'(bus4.busy), 64'd1);
    bus4.run = 1'b0;
    go_to(s + 1700);
    check_output("t6w_busy_end", 64'(bus4.busy), 64'd0);
    check_output("t6w_retired_end", 64'(bus4.retired), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
